sim_test_ctrl: RTL and testbench
================================

Name: sim_test_ctrl

Overview:
Passive simulation-harness controller that snoops the CPU data-write bus and produces a test verdict plus buffered character streams. It decodes a parametrised address window holding one status register and NUM_CHAN fake-UART channels. Each channel has its own DEPTH-entry FIFO, and a round-robin arbiter drains all channels onto one valid/ready character stream. A cycle-timeout watchdog is built in. It sits beside sim_crossbar in the testbench and never drives the bus.

Parameters:
BUS_WIDTH, 32, width of dw_addr/dw_data
BASE_ADDR, 32'h8000, address of status register; UART channel i at BASE_ADDR+4+4*i
NUM_CHAN, 2, number of UART channels (1..8)
DEPTH, 8, per-channel FIFO entries (power of two, >=2)
PASS_MAGIC, 32'd123456789, status value meaning pass
FAIL_MAGIC, 32'd111111111, status value meaning fail
TIMEOUT, 10000, watchdog limit in cycles; 0 disables

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset: synchronous, active-high
dw_data_addr_valid  in  1  snooped write valid
dw_data_addr_ready  in  1  snooped write ready
dw_addr  in  BUS_WIDTH  snooped write address
dw_data  in  BUS_WIDTH  snooped write data
dw_strobe  in  BUS_WIDTH/8  snooped byte strobes
test_done  out  1  sticky: verdict reached
test_passed  out  1  sticky: pass verdict
test_timeout  out  1  sticky: watchdog expired
char_valid  out  1  character available
char_ready  in  1  consumer accepts character
char_data  out  8  character byte
char_chan  out  $clog2(NUM_CHAN) (min 1)  source channel of char_data
overflow  out  NUM_CHAN  sticky per-channel drop flag
cycle_count  out  32  cycles since reset, frozen at test_done

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, FIFOs emptied, arbiter pointer at channel 0, cycle_count=0.
- Write event: dw_data_addr_valid && dw_data_addr_ready at a posedge. Any other cycle is ignored. The block never drives ready.
- Status write (addr==BASE_ADDR):
  - data==PASS_MAGIC -> next cycle test_done=1, test_passed=1.
  - data==FAIL_MAGIC -> test_done=1, test_passed=0.
  - Other values ignored.
  - First verdict wins; status writes after test_done are ignored.
- Watchdog: cycle_count increments every cycle while !test_done.
  - If TIMEOUT!=0 and cycle_count==TIMEOUT-1 with no verdict in that cycle -> next cycle test_done=1, test_timeout=1, test_passed=0.
  - A verdict write in that same cycle wins over timeout.
- UART write (addr==BASE_ADDR+4+4*i, i<NUM_CHAN, dw_strobe[0]=1): push dw_data[7:0] into FIFO i.
  - Writes with dw_strobe[0]=0, or to addresses outside the window, are ignored.
  - Full FIFO: push is accepted if the same FIFO pops in that cycle. Otherwise the byte is dropped and overflow[i] is set (sticky until reset).
  - UART writes are still accepted after test_done so FIFOs keep draining.
- Latency: a byte pushed at edge N can appear on char_valid after edge N (earliest one cycle).
- Output stream:
  - char_valid=1 when the selected channel's FIFO is non-empty.
  - char_data/char_chan show that channel's head.
  - While char_valid && !char_ready, char_data/char_chan/char_valid stay stable.
  - A pop happens on char_valid && char_ready.
- Arbiter (round-robin):
  - Selection is the first non-empty channel starting at the pointer, wrapping past NUM_CHAN-1 to 0.
  - After a pop from channel k, the pointer moves to (k+1) mod NUM_CHAN.
  - The pointer only changes on a pop; the selection is held while stalled.
- FIFO ordering is strict per channel. Pointers wrap modulo DEPTH, and count runs 0..DEPTH.
- Reset mid-stream discards queued bytes and drops char_valid in the cycle after reset is sampled.

Test Plan:
- Pass: after reset, write 123456789 to 0x8000 at cycle 20 -> test_done=1, test_passed=1 the next cycle; cycle_count frozen at 21; a later write of 111111111 is ignored.
- Timeout: TIMEOUT=50, no writes -> test_done=1, test_timeout=1, test_passed=0 after 50 cycles; a FAIL_MAGIC write landing in cycle 49 -> test_timeout stays 0.
- UART order/backpressure: write 'H','i' to 0x8004 with char_ready=0 for 5 cycles -> char_valid=1 and char_data='H' stable; then char_ready=1 -> 'H','i' in order with char_chan=0.
- Round-robin: NUM_CHAN=2; preload 'a','b' to ch0 (0x8004) and 'x','y' to ch1 (0x8008); char_ready=1 -> sequence a/0, x/1, b/0, y/1.
- Overflow: DEPTH=4, char_ready=0, 5 writes to ch0 -> overflow[0]=1 and the FIFO holds only the first 4 bytes; a write to a full FIFO in a pop cycle -> accepted, overflow unchanged.
- Strobe/reset: write with dw_strobe=4'b0010 -> no push; assert rst with 3 queued bytes -> char_valid=0 and all flags cleared.

Source files
------------

// File: rtl/sim_test_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : sim_test_ctrl
// Purpose  : passive write-bus snooper giving a test verdict, a cycle watchdog
//            and per-channel fake-UART FIFOs drained round-robin onto one stream
// Revision : 1.0
// =============================================================================
module sim_test_ctrl #(
  parameter int unsigned          BUS_WIDTH  = 32,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = 32'h8000,
  parameter int unsigned          NUM_CHAN   = 2,
  parameter int unsigned          DEPTH      = 8,
  parameter logic [BUS_WIDTH-1:0] PASS_MAGIC = 32'd123456789,
  parameter logic [BUS_WIDTH-1:0] FAIL_MAGIC = 32'd111111111,
  parameter int unsigned          TIMEOUT    = 10000
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                dw_data_addr_valid,
  input  logic                                                dw_data_addr_ready,
  input  logic [BUS_WIDTH-1:0]                                dw_addr,
  input  logic [BUS_WIDTH-1:0]                                dw_data,
  input  logic [BUS_WIDTH/8-1:0]                              dw_strobe,
  output logic                                                test_done,
  output logic                                                test_passed,
  output logic                                                test_timeout,
  output logic                                                char_valid,
  input  logic                                                char_ready,
  output logic [7:0]                                          char_data,
  output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0]  char_chan,
  output logic [NUM_CHAN-1:0]                                 overflow,
  output logic [31:0]                                         cycle_count
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [AW:0] FULL       = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHAN - 1);
  localparam logic [31:0] LAST_CYCLE = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  logic [7:0]          mem_q     [NUM_CHAN][DEPTH];
  logic [7:0]          mem_d     [NUM_CHAN][DEPTH];
  logic [AW-1:0]       wr_ptr_q  [NUM_CHAN];
  logic [AW-1:0]       wr_ptr_d  [NUM_CHAN];
  logic [AW-1:0]       rd_ptr_q  [NUM_CHAN];
  logic [AW-1:0]       rd_ptr_d  [NUM_CHAN];
  logic [AW:0]         count_q   [NUM_CHAN];
  logic [AW:0]         count_d   [NUM_CHAN];
  logic [NUM_CHAN-1:0] overflow_q, overflow_d;
  logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                hold_q, hold_d;
  logic [CW-1:0]       hold_chan_q, hold_chan_d;
  logic                done_q, done_d;
  logic                passed_q, passed_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         cycle_q, cycle_d;

  logic                wr_event;
  logic                status_hit;
  logic [NUM_CHAN-1:0] nonempty;
  logic [NUM_CHAN-1:0] push_hit;
  logic [NUM_CHAN-1:0] push_ok;
  logic [NUM_CHAN-1:0] pop_vec;
  logic [CW-1:0]       sel;
  logic                sel_found;
  logic                pop;
  int unsigned         scan_idx;
  logic [CW-1:0]       scan_chan;
  logic                unused_strobe;

  assign wr_event      = dw_data_addr_valid && dw_data_addr_ready;
  assign status_hit    = wr_event && (dw_addr == BASE_ADDR);
  assign unused_strobe = ^dw_strobe;

  always_comb begin
    nonempty = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      nonempty[i] = (count_q[i] != '0);
    end
  end

  // A stalled head is pinned via hold so a newly filled, higher-priority
  // channel cannot replace the character the consumer is already looking at.
  always_comb begin
    sel       = rr_ptr_q;
    sel_found = 1'b0;
    scan_idx  = 0;
    scan_chan = '0;
    for (int unsigned off = 0; off < NUM_CHAN; off++) begin
      scan_idx  = (32'(rr_ptr_q) + off) % NUM_CHAN;
      scan_chan = CW'(scan_idx);
      if (!sel_found && nonempty[scan_chan]) begin
        sel       = scan_chan;
        sel_found = 1'b1;
      end
    end
    if (hold_q) begin
      sel       = hold_chan_q;
      sel_found = 1'b1;
    end
  end

  assign char_valid = sel_found && nonempty[sel];
  assign char_data  = char_valid ? mem_q[sel][rd_ptr_q[sel]] : 8'h00;
  assign char_chan  = char_valid ? sel : '0;
  assign pop        = char_valid && char_ready;

  always_comb begin
    push_hit = '0;
    push_ok  = '0;
    pop_vec  = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      push_hit[i] = wr_event && dw_strobe[0] &&
                    (dw_addr == BASE_ADDR + BUS_WIDTH'(4 * (i + 1)));
      pop_vec[i]  = pop && (sel == CW'(i));
      push_ok[i]  = push_hit[i] && ((count_q[i] != FULL) || pop_vec[i]);
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if (push_ok[i]) begin
        mem_d[i][wr_ptr_q[i]] = dw_data[7:0];
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end else if (push_hit[i]) begin
        overflow_d[i] = 1'b1;
      end
      if (pop_vec[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end
      count_d[i] = count_q[i] + (AW+1)'(push_ok[i]) - (AW+1)'(pop_vec[i]);
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    hold_chan_d = hold_chan_q;
    if (pop) begin
      rr_ptr_d = (sel == LAST_CHAN) ? '0 : sel + CW'(1);
      hold_d   = 1'b0;
    end else if (char_valid) begin
      hold_d      = 1'b1;
      hold_chan_d = sel;
    end
  end

  // A real verdict in the watchdog's last cycle takes priority over timeout.
  always_comb begin
    done_d    = done_q;
    passed_d  = passed_q;
    timeout_d = timeout_q;
    cycle_d   = cycle_q;
    if (!done_q) begin
      cycle_d = cycle_q + 32'd1;
      if (status_hit && (dw_data == PASS_MAGIC)) begin
        done_d   = 1'b1;
        passed_d = 1'b1;
      end else if (status_hit && (dw_data == FAIL_MAGIC)) begin
        done_d = 1'b1;
      end else if ((TIMEOUT != 0) && (cycle_q == LAST_CYCLE)) begin
        done_d    = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      overflow_q  <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_chan_q <= '0;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      hold_chan_q <= hold_chan_d;
      done_q      <= done_d;
      passed_q    <= passed_d;
      timeout_q   <= timeout_d;
      cycle_q     <= cycle_d;
    end
  end

  assign test_done    = done_q;
  assign test_passed  = passed_q;
  assign test_timeout = timeout_q;
  assign overflow     = overflow_q;
  assign cycle_count  = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_test_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_sim_test_ctrl
// Purpose  : directed bench for sim_test_ctrl with a queue-based reference model
// Revision : 1.0
// =============================================================================
module tb_sim_test_ctrl;

  localparam int          NCH  = 2;
  localparam int          DEP  = 4;
  localparam int          TMO  = 50;
  localparam logic [31:0] BASE = 32'h8000;
  localparam logic [31:0] PASS_V = 32'd123456789;
  localparam logic [31:0] FAIL_V = 32'd111111111;

  logic        clk;
  logic        rst;
  logic        dv, dr;
  logic [31:0] addr, data;
  logic [3:0]  strb;
  logic        char_ready;
  logic        test_done, test_passed, test_timeout, char_valid;
  logic [7:0]  char_data;
  logic [0:0]  char_chan;
  logic [1:0]  overflow;
  logic [31:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  sim_test_ctrl #(
    .BUS_WIDTH(32), .BASE_ADDR(BASE), .NUM_CHAN(NCH), .DEPTH(DEP),
    .PASS_MAGIC(PASS_V), .FAIL_MAGIC(FAIL_V), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .dw_data_addr_valid(dv), .dw_data_addr_ready(dr),
    .dw_addr(addr), .dw_data(data), .dw_strobe(strb),
    .test_done(test_done), .test_passed(test_passed), .test_timeout(test_timeout),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_chan(char_chan),
    .overflow(overflow), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus verdict bookkeeping.
  logic [7:0]  mq [NCH][$];
  bit          m_done, m_passed, m_timeout, m_hold, cmp_en;
  bit [1:0]    m_ovf;
  int          m_cycle, m_ptr, m_hold_chan;
  int          ms, cs;
  bit          mpop, mwev;
  logic [7:0]  dump;

  function automatic int m_pick();
    if (m_hold) return m_hold_chan;
    for (int k = 0; k < NCH; k++) begin
      if (mq[(m_ptr + k) % NCH].size() > 0) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
      m_done = 0; m_passed = 0; m_timeout = 0; m_hold = 0;
      m_ovf = '0; m_cycle = 0; m_ptr = 0; m_hold_chan = 0;
      cmp_en = 1;
    end else begin
      ms   = m_pick();
      mpop = (ms >= 0) && char_ready;
      mwev = dv && dr;
      if (!m_done) begin
        if (mwev && addr == BASE && data == PASS_V) begin
          m_done = 1; m_passed = 1;
        end else if (mwev && addr == BASE && data == FAIL_V) begin
          m_done = 1;
        end else if (m_cycle == TMO - 1) begin
          m_done = 1; m_timeout = 1;
        end
        m_cycle++;
      end
      if (mpop) begin
        dump   = mq[ms].pop_front();
        m_ptr  = (ms + 1) % NCH;
        m_hold = 0;
      end else if (ms >= 0) begin
        m_hold = 1; m_hold_chan = ms;
      end
      for (int k = 0; k < NCH; k++) begin
        if (mwev && strb[0] && addr == BASE + 32'(4 * (k + 1))) begin
          if (mq[k].size() < DEP) mq[k].push_back(data[7:0]);
          else m_ovf[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cs = m_pick();
      checks++;
      if (test_done !== m_done || test_passed !== m_passed || test_timeout !== m_timeout ||
          cycle_count !== 32'(m_cycle) || overflow !== m_ovf || char_valid !== (cs >= 0) ||
          (cs >= 0 && (char_data !== mq[cs][0] || char_chan !== 1'(cs)))) begin
        failures++;
        $display("FAIL model t=%0t dut d/p/t=%b%b%b cyc=%0d ovf=%b v=%b ch=%0d dat=%h | model d/p/t=%b%b%b cyc=%0d ovf=%b sel=%0d",
                 $time, test_done, test_passed, test_timeout, cycle_count, overflow, char_valid,
                 char_chan, char_data, m_done, m_passed, m_timeout, m_cycle, m_ovf, cs);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dv = 1; dr = 1; addr = a; data = d; strb = s;
    @(negedge clk);
    dv = 0; dr = 0; strb = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  logic [8:0] rxq [$];

  task automatic drain(input int n);
    int budget;
    rxq.delete();
    char_ready = 1;
    budget = 0;
    while (rxq.size() < n && budget < 40) begin
      if (char_valid) rxq.push_back({char_chan, char_data});
      @(negedge clk);
      budget++;
    end
    char_ready = 0;
    checks++;
    if (rxq.size() != n) begin
      failures++;
      $display("FAIL drain: got %0d chars expected %0d", rxq.size(), n);
    end
  endtask

  logic [8:0] exp_hi [2] = '{9'h048, 9'h069};
  logic [8:0] exp_rr [4] = '{9'h061, 9'h178, 9'h062, 9'h179};
  logic [8:0] exp_ov [4] = '{9'h032, 9'h033, 9'h034, 9'h036};

  initial begin
    rst = 1; dv = 0; dr = 0; addr = '0; data = '0; strb = '0; char_ready = 0;
    @(negedge clk);
    do_reset();
    chk("reset_done", 32'(test_done), 0);
    chk("reset_passed", 32'(test_passed), 0);
    chk("reset_timeout", 32'(test_timeout), 0);
    chk("reset_valid", 32'(char_valid), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_cycle", cycle_count, 0);

    // Pass verdict written while cycle_count reads 20.
    repeat (20) @(negedge clk);
    bus_wr(BASE, PASS_V, 4'hF);
    chk("pass_done", 32'(test_done), 1);
    chk("pass_passed", 32'(test_passed), 1);
    chk("pass_cycle", cycle_count, 21);
    repeat (3) @(negedge clk);
    bus_wr(BASE, FAIL_V, 4'hF);
    repeat (40) @(negedge clk);
    chk("pass_sticky", 32'(test_passed), 1);
    chk("pass_frozen", cycle_count, 21);
    chk("pass_no_tmo", 32'(test_timeout), 0);

    // Watchdog expiry.
    do_reset();
    bus_wr(BASE, 32'd5, 4'hF);
    repeat (48) @(negedge clk);
    chk("tmo_before", 32'(test_done), 0);
    @(negedge clk);
    chk("tmo_done", 32'(test_done), 1);
    chk("tmo_flag", 32'(test_timeout), 1);
    chk("tmo_passed", 32'(test_passed), 0);
    chk("tmo_cycle", cycle_count, 50);

    // Fail verdict in the last watchdog cycle beats the timeout.
    do_reset();
    repeat (49) @(negedge clk);
    bus_wr(BASE, FAIL_V, 4'hF);
    chk("late_fail_done", 32'(test_done), 1);
    chk("late_fail_tmo", 32'(test_timeout), 0);
    chk("late_fail_passed", 32'(test_passed), 0);

    // Ordering under backpressure.
    do_reset();
    bus_wr(BASE + 4, 32'h48, 4'h1);
    bus_wr(BASE + 4, 32'h69, 4'h1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(char_valid), 1);
      chk("stall_data", 32'(char_data), 32'h48);
      @(negedge clk);
    end
    drain(2);
    for (int k = 0; k < 2; k++) chk("hi_order", 32'(rxq[k]), 32'(exp_hi[k]));
    chk("hi_empty", 32'(char_valid), 0);

    // Round-robin across both channels.
    do_reset();
    bus_wr(BASE + 4, 32'h61, 4'h1);
    bus_wr(BASE + 4, 32'h62, 4'h1);
    bus_wr(BASE + 8, 32'h78, 4'h1);
    bus_wr(BASE + 8, 32'h79, 4'h1);
    drain(4);
    for (int k = 0; k < 4; k++) chk("rr_order", 32'(rxq[k]), 32'(exp_rr[k]));

    // Overflow, then a push into a full FIFO during a pop.
    do_reset();
    for (int k = 1; k <= 5; k++) bus_wr(BASE + 4, 32'h30 + 32'(k), 4'h1);
    chk("ovf_set", 32'(overflow), 32'h1);
    char_ready = 1;
    bus_wr(BASE + 4, 32'h36, 4'h1);
    char_ready = 0;
    chk("ovf_pop_push", 32'(overflow), 32'h1);
    drain(4);
    for (int k = 0; k < 4; k++) chk("ovf_order", 32'(rxq[k]), 32'(exp_ov[k]));

    // Ignored writes, then reset with queued bytes and set flags.
    do_reset();
    bus_wr(BASE + 4, 32'h7A, 4'b0010);
    bus_wr(BASE + 12, 32'h71, 4'h1);
    dv = 1; dr = 0; addr = BASE + 4; data = 32'h70; strb = 4'h1;
    @(negedge clk);
    dv = 0; strb = '0;
    chk("ignored_valid", 32'(char_valid), 0);
    bus_wr(BASE + 4, 32'h31, 4'h1);
    bus_wr(BASE + 8, 32'h32, 4'h1);
    bus_wr(BASE + 4, 32'h33, 4'h1);
    for (int k = 0; k < 5; k++) bus_wr(BASE + 8, 32'h40, 4'h1);
    bus_wr(BASE, PASS_V, 4'hF);
    chk("pre_rst_valid", 32'(char_valid), 1);
    chk("pre_rst_ovf", 32'(overflow), 32'h2);
    rst = 1;
    @(negedge clk);
    chk("rst_valid", 32'(char_valid), 0);
    chk("rst_done", 32'(test_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cycle", cycle_count, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
